// File: rtl/pdm_modulator.sv
// pdm_modulator: first-order sigma-delta PDM modulator with zero-order-hold
// interpolation. Signed PCM samples arrive over a valid/ready handshake into a
// one-deep buffer. Each sample is held for R modulator ticks and noise-shaped
// into a 1-bit stream.
module pdm_modulator #(
   parameter int N  = 16,  // PCM sample width, signed
   parameter int R  = 10,  // modulator ticks per PCM sample, R >= 2
   parameter int CW = 4    // tick counter width, 2^CW >= R
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   output logic         in_ready,
   output logic         pdm_out,
   output logic         sample_strobe,
   output logic         underflow
);

   // The accumulator is N+2 bits. |acc| <= FS always holds, so acc + cur
   // stays inside +/-2^(N+1) for every input and needs no saturation.
   localparam int AW = N + 2;
   localparam logic signed [AW-1:0] FS   = {3'b001, {(N-1){1'b0}}};
   localparam logic [CW-1:0]        LAST = CW'(R - 1);

   logic [N-1:0]          buf_data;
   logic                  buf_valid;
   logic signed [N-1:0]   cur;
   logic signed [AW-1:0]  acc;
   logic signed [AW-1:0]  v;
   logic signed [AW-1:0]  acc_next;
   logic [CW-1:0]         tick_cnt;
   logic                  xfer;
   logic                  boundary;
   logic                  bit_now;

   assign in_ready = !buf_valid;
   assign xfer     = in_valid && in_ready;
   assign boundary = we && (tick_cnt == LAST);

   // Quantiser: sign of acc + held sample decides the bit, and the feedback
   // subtracts +FS or -FS accordingly.
   assign v        = acc + {{2{cur[N-1]}}, cur};
   assign bit_now  = ~v[AW-1];
   assign acc_next = bit_now ? (v - FS) : (v + FS);

   // Tick counter: advances on every modulator tick, wraps on the boundary tick.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           tick_cnt <= '0;
      else if (boundary) tick_cnt <= '0;
      else if (we)       tick_cnt <= tick_cnt + 1'b1;
   end

   // Sigma-delta loop: the tick that loads a new sample still modulates the
   // old one, so the new value takes effect from the following tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         pdm_out <= 1'b0;
      end else if (we) begin
         acc     <= acc_next;
         pdm_out <= bit_now;
      end
   end

   // Buffer payload: only meaningful while buf_valid is set.
   // NOTE: the data register carries no reset; buf_valid alone qualifies it,
   // so resetting the payload would add reset fan-out for no behavioural gain.
   always_ff @(posedge clk) begin
      if (xfer) buf_data <= in_data;
   end

   // Buffer occupancy, held sample and boundary pulses. On an empty boundary
   // a same-cycle transfer bypasses the buffer straight into cur.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid     <= 1'b0;
         cur           <= '0;
         sample_strobe <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         sample_strobe <= 1'b0;
         underflow     <= 1'b0;
         if (boundary) begin
            if (buf_valid) begin
               cur           <= buf_data;
               buf_valid     <= 1'b0;
               sample_strobe <= 1'b1;
            end else if (xfer) begin
               cur           <= in_data;
               sample_strobe <= 1'b1;
            end else begin
               underflow     <= 1'b1;
            end
         end else if (xfer) begin
            buf_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pdm_modulator.sv
// tb_pdm_modulator: scoreboard bench for pdm_modulator. Each driven cycle
// pushes the expected outputs from a behavioural integer model; they are
// popped and compared one clock later. Directed checks cover the idle tone,
// ones density, full-scale inputs, backpressure, bypass and async reset.
module tb_pdm_modulator;

   localparam int N  = 16;
   localparam int R  = 10;
   localparam int CW = 4;
   localparam int FS = 32768;

   typedef struct {
      logic pdm;
      logic strobe;
      logic uf;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         we;
   logic         in_valid;
   logic [N-1:0] in_data;
   logic         in_ready;
   logic         pdm_out;
   logic         sample_strobe;
   logic         underflow;

   int   n_total;
   int   n_bad;
   exp_t sb_q[$];

   // behavioural model state
   int   acc_m, cur_m, buf_m, bv_m, cnt_m;
   logic pdm_m;

   // last observed outputs, for directed checks
   logic obs_pdm, obs_strobe, obs_uf;

   pdm_modulator #(.N(N), .R(R), .CW(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .we            (we),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .pdm_out       (pdm_out),
      .sample_strobe (sample_strobe),
      .underflow     (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      acc_m = 0; cur_m = 0; buf_m = 0; bv_m = 0; cnt_m = 0; pdm_m = 1'b0;
   endtask

   // One clock cycle: drive inputs, predict, push; after the edge pop and compare.
   task automatic step(input logic w, input logic vld, input int d);
      exp_t e;
      exp_t got;
      int   v;
      logic xf;
      logic bnd;
      logic [31:0] dv;
      dv       = d;
      we       = w;
      in_valid = vld;
      in_data  = dv[N-1:0];
      check("in_ready", in_ready, (bv_m == 0));
      xf       = vld && (bv_m == 0);
      e.strobe = 1'b0;
      e.uf     = 1'b0;
      if (w) begin
         v     = acc_m + cur_m;
         pdm_m = (v >= 0);
         acc_m = pdm_m ? v - FS : v + FS;
         bnd   = (cnt_m == R - 1);
         cnt_m = bnd ? 0 : cnt_m + 1;
         if (bnd) begin
            if (bv_m != 0) begin
               cur_m = buf_m; bv_m = 0; e.strobe = 1'b1;
            end else if (xf) begin
               cur_m = d; e.strobe = 1'b1; xf = 1'b0;
            end else begin
               e.uf = 1'b1;
            end
         end
      end
      if (xf) begin
         buf_m = d; bv_m = 1;
      end
      e.pdm = pdm_m;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got.pdm    = pdm_out;
      got.strobe = sample_strobe;
      got.uf     = underflow;
      e = sb_q.pop_front();
      check("pdm_out", got.pdm, e.pdm);
      check("sample_strobe", got.strobe, e.strobe);
      check("underflow", got.uf, e.uf);
      obs_pdm    = got.pdm;
      obs_strobe = got.strobe;
      obs_uf     = got.uf;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int ones;
      int ufs;
      int loaded;
      n_total  = 0;
      n_bad    = 0;
      rst      = 1'b1;
      we       = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_pdm", pdm_out, 0);
      check("rst_strobe", sample_strobe, 0);
      check("rst_uf", underflow, 0);
      check("rst_ready", in_ready, 1);
      rst = 1'b0;

      // 1: idle tone, underflow every R ticks
      ufs = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 0);
         check("idle_tone", obs_pdm, (i % 2 == 0));
         ufs += obs_uf;
      end
      check("idle_uf_count", ufs, 2);

      // 2: x=16384 accepted while idle, 30 ones per 40 ticks after load
      step(1'b0, 1'b1, 16384);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);
      check("half_strobe", obs_strobe, 1);
      ones = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 0);
         check("half_pattern", obs_pdm, (i % 4 != 2));
         ones += obs_pdm;
      end
      check("half_density", ones, 30);

      // 3: -FS streamed back to back, then FS-1
      do_reset();
      ufs = 0;
      loaded = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b1, 1'b1, -32768);
         if (loaded != 0) check("negfs_zero", obs_pdm, 0);
         if (obs_strobe) loaded = 1;
         ufs += obs_uf;
      end
      step(1'b1, 1'b1, 32767);
      ufs += obs_uf;
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, 0);
         check("negfs_zero", obs_pdm, 0);
         ufs += obs_uf;
      end
      check("negfs_no_uf", ufs, 0);
      check("posfs_strobe", obs_strobe, 1);
      ones = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 0);
         ones += obs_pdm;
      end
      check("posfs_ones", ones, 10);

      // 4: backpressure with we=0, second sample stalled until boundary
      step(1'b0, 1'b1, 1000);
      check("bp_ready_low", in_ready, 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, -2000);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, -2000);
      check("bp_load_strobe", obs_strobe, 1);
      check("bp_ready_back", in_ready, 1);
      step(1'b1, 1'b1, -2000);
      check("bp_second_taken", in_ready, 0);

      // 5: empty buffer, in_valid exactly on the boundary tick -> bypass
      while (!(cnt_m == R - 1 && bv_m == 0)) step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, -12345);
      check("byp_strobe", obs_strobe, 1);
      check("byp_uf", obs_uf, 0);
      check("byp_buf_empty", in_ready, 1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0);

      // 6: async reset with tick_cnt=5 and a buffered sample
      while (cnt_m != 0) step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 20000);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);
      check("pre_rst_ready", in_ready, 0);
      #1;
      rst = 1'b1;
      #2;
      check("arst_pdm", pdm_out, 0);
      check("arst_strobe", sample_strobe, 0);
      check("arst_uf", underflow, 0);
      check("arst_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 0);
         check("post_rst_tone", obs_pdm, (i % 2 == 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
